// File: rtl/game_pkg.sv
// Shared types and constants for the memorization game blocks.
// Holds key width, FSM state encoding and the default sequence length.
package game_pkg;

  localparam int KEY_W       = 4;
  localparam int DEF_MAX_LEN = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT,
    S_DONE    = ST_DONE
  } state_e;

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector, also used for button pulses.
// Ports: clk, rst_n (async low), in_i level, rise_o high while in_i is newly high.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= in_i;
  end

  assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/key_sequence_checker.sv
// Checks decoded keypad presses in order against a latched target sequence.
// Ports: clk, rst (async low), start/target/seq_len round setup, value/valueReady
// from keyboard_decoder; busy, key_strobe, last_key, entry_count, done, pass,
// fail_timeout back to the game FSM.
module key_sequence_checker
  import game_pkg::*;
#(
  parameter int MAX_LEN        = DEF_MAX_LEN,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KEY_W*MAX_LEN-1:0] target,
  input  logic [4:0]               seq_len,
  input  logic [15:0]              value,
  input  logic                     valueReady,
  output logic                     busy,
  output logic                     key_strobe,
  output logic [KEY_W-1:0]         last_key,
  output logic [4:0]               entry_count,
  output logic                     done,
  output logic                     pass,
  output logic                     fail_timeout
);

  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);
  localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
  // Timeout fires on the idle cycle where the counter would reach this.
  localparam logic [CNT_W:0] TO_LIM =
    (CNT_W+1)'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                   state_q, state_d;
  logic [KEY_W*MAX_LEN-1:0] tgt_q, tgt_d;
  logic [4:0]               len_q, len_d;
  logic [4:0]               ent_q, ent_d;
  logic [CNT_W-1:0]         idle_q, idle_d;
  logic [KEY_W-1:0]         last_q, last_d;
  logic                     busy_q, busy_d;
  logic                     stb_q, stb_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic                     fto_q, fto_d;

  logic                     rise;
  logic                     key_ok;
  logic                     to_hit;
  logic [4:0]               ent_inc;
  logic [4:0]               len_clamp;
  logic [KEY_W-1:0]         exp_key;

  rise_detect u_rise (
    .clk    (clk),
    .rst_n  (rst),
    .in_i   (valueReady),
    .rise_o (rise)
  );

  // Codes with upper bits set are not keypad keys.
  assign key_ok = rise & ~|value[15:4];

  assign ent_inc = (ent_q == LEN_MAX) ? ent_q : ent_q + 5'd1;

  assign len_clamp = (seq_len == 5'd0)   ? 5'd1    :
                     (seq_len > LEN_MAX) ? LEN_MAX :
                     seq_len;

  assign to_hit = TO_EN &&
    (({1'b0, idle_q} + (CNT_W+1)'(1)) >= TO_LIM);

  always_comb begin
    exp_key = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (ent_q == 5'(i)) exp_key = tgt_q[i*KEY_W +: KEY_W];
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    ent_d   = ent_q;
    idle_d  = idle_q;
    last_d  = last_q;
    busy_d  = busy_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fto_d   = fto_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tgt_d   = target;
          len_d   = len_clamp;
          ent_d   = 5'd0;
          idle_d  = '0;
          pass_d  = 1'b0;
          fto_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // A key on the expiry cycle takes priority over the timeout.
        if (key_ok) begin
          stb_d  = 1'b1;
          last_d = value[KEY_W-1:0];
          ent_d  = ent_inc;
          idle_d = '0;
          if (value[KEY_W-1:0] != exp_key) begin
            pass_d  = 1'b0;
            state_d = S_DONE;
          end else if (ent_inc == len_q) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end
        end else if (to_hit) begin
          pass_d  = 1'b0;
          fto_d   = 1'b1;
          state_d = S_DONE;
        end else if (TO_EN) begin
          idle_d = idle_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      len_q   <= '0;
      ent_q   <= '0;
      idle_q  <= '0;
      last_q  <= '0;
      busy_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      len_q   <= len_d;
      ent_q   <= ent_d;
      idle_q  <= idle_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fto_q   <= fto_d;
    end
  end

  assign busy         = busy_q;
  assign key_strobe   = stb_q;
  assign last_key     = last_q;
  assign entry_count  = ent_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail_timeout = fto_q;

endmodule

// File: doc/key_sequence_checker.md
Name: key_sequence_checker

Overview:
- Downstream consumer of keyboard_decoder in the memorization game.
- Takes decoded keypad values, accepts exactly one key per press, and compares each key in order against the target sequence loaded by the game controller.
- Reports pass or fail, with an optional inactivity timeout, back to the game FSM.

Parameters:
- MAX_LEN, 16: maximum sequence length in keys.
- TIMEOUT_CYCLES, 100_000_000: idle cycles allowed between keys before failing. A value of 0 disables the timeout.
- CNT_W, 27: width of the timeout counter. It must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that latches target/seq_len and begins a round.
- target  in  4*MAX_LEN  expected keys; key i is at target[4i+3:4i], key 0 first.
- seq_len  in  5  number of keys in this round, 1..MAX_LEN.
- value  in  16  key code from keyboard_decoder; value[3:0] is the key index.
- valueReady  in  1  level signal from keyboard_decoder, high while a decoded key is held.
- busy  out  1  round in progress.
- key_strobe  out  1  one-cycle pulse per accepted key.
- last_key  out  4  most recently accepted key.
- entry_count  out  5  keys accepted this round.
- done  out  1  one-cycle pulse at round end.
- pass  out  1  result of the last round, valid from done until the next start.
- fail_timeout  out  1  last round failed by timeout.

Behaviour:
- Reset (rst low, asynchronous): every output is 0.
  - State is IDLE.
  - Latched target, length and timeout counter are cleared.
  - The valueReady edge register is cleared.
- Key acceptance:
  - A key is accepted on the rising edge of valueReady, registered one cycle.
  - A key is accepted only in COLLECT.
  - If value[15:4] is nonzero, the key is ignored (no strobe) and compared against nothing.
  - A held key is accepted once only.
  - If valueReady is already high when a round starts, that press is not accepted.
- FSM:
  - IDLE: on start, latch target and seq_len (0 is clamped to 1, values above MAX_LEN to MAX_LEN).
    - Clear entry_count, pass and fail_timeout; busy is 1; go to COLLECT.
  - COLLECT, on an accepted key k:
    - The cycle after the accepting edge, key_strobe pulses, last_key is k, entry_count increments, and the timeout counter clears.
    - If k differs from target[entry_count]: go to DONE with pass=0.
    - Else if the new entry_count equals the length: go to DONE with pass=1.
  - COLLECT, on timeout: the counter increments every cycle without an accepted key.
    - When it reaches TIMEOUT_CYCLES-1, go to DONE with pass=0 and fail_timeout=1.
    - A key arriving in the same cycle as the timeout wins; the timeout is ignored.
  - DONE: done pulses for exactly 1 cycle and busy drops in the same cycle; go to IDLE.
- Latency: the key_strobe for the final key and done are one cycle apart, with done on the following cycle.
- start is ignored while busy. A round cannot be restarted mid-round except by reset.
- Reset mid-round aborts the round with no done pulse.
- entry_count saturates at MAX_LEN and never wraps.
- last_key, entry_count and pass hold their values in IDLE until the next start.

Decomposition:
- Shared package game_pkg holds:
  - KEY_W=4;
  - state encoding localparams ST_IDLE, ST_COLLECT, ST_DONE;
  - MAX_LEN default.
- One sub-module, rise_detect (a one-flop rising-edge detector with active-low async reset), is used for valueReady. The team also reuses it elsewhere for button pulses.

Test Plan:
- Correct entry: start with seq_len=3, target keys 0,4,7; press 0, 4, 7 (valueReady high 40 cycles each, 50-cycle gaps).
  - Expect three key_strobe pulses, entry_count 1, 2, 3, last_key 7.
  - Expect done one cycle after the third strobe, pass=1, fail_timeout=0.
- Wrong key: target 0,4,7; press 0 then 5.
  - Expect done after the second strobe, pass=0, entry_count=2, last_key=5; later presses produce no strobe.
- Held key and bad code:
  - Hold valueReady high for 500 cycles: exactly one strobe.
  - value=16'h0013 with valueReady: no strobe and entry_count unchanged.
- Timeout: TIMEOUT_CYCLES=50, start, no keys.
  - Expect done 50 cycles into COLLECT, pass=0, fail_timeout=1.
  - A key on the expiry cycle is accepted instead, with no fail.
- Start edge cases:
  - start with seq_len=0 acts as length 1.
  - start while busy is ignored.
  - valueReady already high at start is not counted until released and pressed again.
- Reset mid-round: after 1 key, pulse rst low asynchronously between clock edges.
  - All outputs are 0 immediately, no done pulse, and a new start works normally.
